// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Picks which port wins an IDLE-cycle request; MEM_ARB_ROUND_ROBIN_EN adds a
// last-grant flag so ties alternate instead of always favouring the CPU.
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic reset_n,
    input  logic grant_take,
`endif
    input  logic cpu_req,
    input  logic dma_req,
    output logic grant_port
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (grant_take) begin
            last_d = grant_port;
        end
    end

    // Starts at DMA so the first tie after reset goes to the CPU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= PORT_DMA;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant_port = PORT_CPU;
        if (cpu_req && dma_req) begin
            grant_port = (last_q == PORT_CPU) ? PORT_DMA : PORT_CPU;
        end else if (dma_req) begin
            grant_port = PORT_DMA;
        end
    end
`else
    always_comb begin
        grant_port = PORT_CPU;
        if (!cpu_req && dma_req) begin
            grant_port = PORT_DMA;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter in front of a single-port synchronous RAM.
// Optional MEM_ARB_ROUND_ROBIN_EN switches tie-breaking to round robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic [31:0]       dma_rdata,
    output logic              dma_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       dma_rdata_q, dma_rdata_d;
    logic              grant_port;
    logic              grant_take;

    mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk        (clk),
        .reset_n    (reset_n),
        .grant_take (grant_take),
`endif
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .grant_port (grant_port)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        grant_take  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_take = 1'b1;
                    gnt_d      = grant_port;
                    cnt_d      = WAIT_INIT;
                    state_d    = ACCESS;
                    if (grant_port == PORT_DMA) begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                // ram_rdata is only trustworthy in the final access cycle.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (gnt_q == PORT_DMA) begin
                            dma_rdata_d = ram_rdata;
                        end else begin
                            cpu_rdata_d = ram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_q       <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Strobes decode straight from the state flop so reset kills them at once.
    assign ram_en    = (state_q == ACCESS);
    assign ram_we    = (state_q == ACCESS) && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign cpu_ack   = (state_q == DONE) && (gnt_q == PORT_CPU);
    assign dma_ack   = (state_q == DONE) && (gnt_q == PORT_DMA);
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 9, memory word-address width.
REQ-002 Parameter WAIT_STATES, 1, extra RAM access cycles, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cpu_req / cpu_we  input  1 / 1  CPU (MAR/MDR path) access request, held until ack; write when 1.
REQ-006 cpu_addr / cpu_wdata  input  ADDR_W / 32  CPU address and write data, valid while cpu_req is high.
REQ-007 cpu_rdata / cpu_ack  output  32 / 1  registered read data; one-cycle completion pulse.
REQ-008 dma_req / dma_we / dma_addr / dma_wdata  input  1 / 1 / ADDR_W / 32  DMA-port request, same rules as the CPU port.
REQ-009 dma_rdata / dma_ack  output  32 / 1  DMA read data and completion pulse.
REQ-010 ram_en / ram_we / ram_addr / ram_wdata  output  1 / 1 / ADDR_W / 32  synchronous RAM port.
REQ-011 ram_rdata  input  32  RAM read data, valid in the last ACCESS cycle.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-013 In IDLE, when any request is high at a rising edge, the arbiter SHALL grant one port, latch its we/addr/wdata, load the wait counter with WAIT_STATES and enter ACCESS.
REQ-014 With both requests high, the grant SHALL go to the CPU (fixed priority) unless REQ-029 applies.
REQ-015 In ACCESS, ram_en SHALL be 1 and ram_we/addr/wdata SHALL come from the latched values only, independent of live inputs.
REQ-016 In ACCESS, the counter SHALL decrement each cycle; at counter==0 the arbiter SHALL capture ram_rdata into the granted port's rdata register (reads only) and enter DONE.
REQ-017 In DONE, only the granted port's ack SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-018 Latency: ack SHALL be high in the cycle beginning WAIT_STATES+1 rising edges after the granting edge.
REQ-019 A write SHALL leave the port's rdata register unchanged.
REQ-020 The non-granted port's outputs SHALL be unchanged during the other port's transaction.
REQ-021 A request deasserted mid-transaction SHALL NOT abort it; the access completes and ack is still pulsed.
REQ-022 Requesters drop req at the edge ending their ack cycle; IDLE SHALL sample req only after DONE, so no duplicate access occurs.
REQ-023 ram_en, ram_we and both acks SHALL be 0 in IDLE and DONE.
REQ-024 Back-to-back service SHALL have one IDLE cycle between DONE and the next ACCESS.

Reset
REQ-025 Asserting reset_n low SHALL immediately force IDLE; counter 0; all acks, ram_en and ram_we 0; rdata registers, ram_addr and ram_wdata 0.
REQ-026 Reset during ACCESS SHALL abandon the transaction without an ack; RAM writes stop at once.
REQ-027 After reset release, the first rising edge SHALL evaluate requests from IDLE.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-029 When defined, a last-grant flag (reset to DMA) SHALL give a tie to the port not granted most recently; when undefined, the flag SHALL be absent and REQ-014 fixed priority applies.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), port-ID constants (PORT_CPU=0, PORT_DMA=1) and the wait-counter width (4).
REQ-031 Grant selection, plus the last-grant flag when MEM_ARB_ROUND_ROBIN_EN is defined, SHALL sit in sub-module mem_arb_grant; the FSM, latches and datapath stay in mem_arbiter.

Verification
REQ-032 WAIT_STATES=1: CPU write addr 0x010 data 0xDEADBEEF, then CPU read 0x010 -> ram_en high 2 cycles each; cpu_ack 2 edges after grant; cpu_rdata=0xDEADBEEF.
REQ-033 Both requests in the same IDLE cycle, macro undefined, 3 rounds -> CPU served every round first, DMA after; strict alternation never occurs.
REQ-034 Same stimulus with MEM_ARB_ROUND_ROBIN_EN -> grants CPU, DMA, CPU, DMA...; first tie after reset goes to CPU.
REQ-035 WAIT_STATES=0: DMA read 0x1FF holding 0x12345678 -> dma_ack 1 edge after grant; dma_rdata=0x12345678; cpu_rdata unchanged.
REQ-036 reset_n low in the 2nd ACCESS cycle (WAIT_STATES=3) of a CPU write -> ram_en/ram_we 0 immediately; no cpu_ack; FSM IDLE after release.
REQ-037 cpu_req dropped one cycle after grant -> access completes; cpu_ack pulses once; no second access.
